// File: rtl/cursor_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cursor_overlay_pkg
// Description : Shared timing and colour constants for the 800x600 video path,
//               RGB type and the cursor coordinate clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cursor_overlay_pkg;

  // Raster timing shared with the sync/position generator (800x600 @ 60 Hz)
  localparam int H_DISPLAY = 800;
  localparam int V_DISPLAY = 600;
  localparam int H_MAX     = 1055;
  localparam int V_MAX     = 627;

  // Cursor geometry
  localparam int CUR_W = 16;
  localparam int CUR_H = 16;

  // Cursor position limits and the centred home position
  localparam logic [10:0] X_MAX  = 11'(H_DISPLAY - CUR_W);
  localparam logic [10:0] Y_MAX  = 11'(V_DISPLAY - CUR_H);
  localparam logic [10:0] X_HOME = 11'((H_DISPLAY - CUR_W) / 2);
  localparam logic [10:0] Y_HOME = 11'((V_DISPLAY - CUR_H) / 2);

  // 4:4:4 pixel colour {R,G,B}
  typedef logic [11:0] rgb_t;

  localparam rgb_t BG_RGB     = 12'h124;
  localparam rgb_t BORDER_RGB = 12'hFFF;
  localparam rgb_t FILL_NONE  = 12'h000;
  localparam rgb_t FILL_LEFT  = 12'hF00;
  localparam rgb_t FILL_RIGHT = 12'h0F0;
  localparam rgb_t FILL_BOTH  = 12'hFF0;

  // Clamp a signed 13-bit candidate coordinate into [0, hi]
  function automatic logic [10:0] clamp_coord(input logic signed [12:0] val,
                                              input logic [10:0]        hi);
    logic signed [12:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (val < 13'sd0) begin
      return 11'd0;
    end else if (val > hi_s) begin
      return hi;
    end else begin
      return val[10:0];
    end
  endfunction

  // Interior colour selected by the committed button state
  function automatic rgb_t fill_colour(input logic left, input logic right);
    case ({left, right})
      2'b10:   return FILL_LEFT;
      2'b01:   return FILL_RIGHT;
      2'b11:   return FILL_BOTH;
      default: return FILL_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_overlay_pos_accum.sv
`default_nettype none
// ============================================================================
// Module      : cursor_pos_accum
// Description : Clamped mouse-movement accumulator with frame-synchronous
//               commit so the drawn cursor never moves mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_pos_accum
  import cursor_overlay_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        commit,
  output logic [10:0] cur_x,
  output logic [10:0] cur_y,
  output logic        cur_btn_l,
  output logic        cur_btn_r
);

  logic [10:0]        pend_x;
  logic [10:0]        pend_y;
  logic               pend_l;
  logic               pend_r;
  logic signed [12:0] step_x;
  logic signed [12:0] step_y;
  logic signed [12:0] sum_x;
  logic signed [12:0] sum_y;

  // PS/2 dy is positive-up while screen lines grow downward, hence the subtract
  assign step_x = $signed({{4{dx[8]}}, dx});
  assign step_y = $signed({{4{dy[8]}}, dy});
  assign sum_x  = $signed({2'b00, pend_x}) + step_x;
  assign sum_y  = $signed({2'b00, pend_y}) - step_y;

  // Pending state: every packet is folded in, clamped to the visible range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x <= X_HOME;
      pend_y <= Y_HOME;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else if (pkt_valid) begin
      pend_x <= clamp_coord(sum_x, X_MAX);
      pend_y <= clamp_coord(sum_y, Y_MAX);
      pend_l <= btn_l;
      pend_r <= btn_r;
    end
  end

  // Committed state: copied once per frame; a coincident packet lands next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x     <= X_HOME;
      cur_y     <= Y_HOME;
      cur_btn_l <= 1'b0;
      cur_btn_r <= 1'b0;
    end else if (commit) begin
      cur_x     <= pend_x;
      cur_y     <= pend_y;
      cur_btn_l <= pend_l;
      cur_btn_r <= pend_r;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cursor_overlay.sv
`default_nettype none
// ============================================================================
// Module      : cursor_overlay
// Description : Draws a 16x16 box cursor over a flat background. Syncs, data
//               enable and colour leave through a common 2-cycle pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_overlay
  import cursor_overlay_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        pkt_valid,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  input  logic        btn_l,
  input  logic        btn_r,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [10:0] cur_x,
  output logic [10:0] cur_y
);

  logic        commit;
  logic        cur_btn_l;
  logic        cur_btn_r;

  // First blanking line: nothing is being drawn, safe to move the cursor
  assign commit = (hpos == 11'd0) && (vpos == 11'(V_DISPLAY));

  cursor_pos_accum u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkt_valid (pkt_valid),
    .dx        (dx),
    .dy        (dy),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .commit    (commit),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .cur_btn_l (cur_btn_l),
    .cur_btn_r (cur_btn_r)
  );

  // ---------------- Stage 1: geometry against the committed cursor ----------
  logic [10:0] ox;
  logic [10:0] oy;
  logic [11:0] x_end;
  logic [11:0] y_end;
  logic        inbox;

  assign ox    = hpos - cur_x;
  assign oy    = vpos - cur_y;
  assign x_end = {1'b0, cur_x} + 12'(CUR_W);
  assign y_end = {1'b0, cur_y} + 12'(CUR_H);
  assign inbox = display_on
              && (hpos >= cur_x) && ({1'b0, hpos} < x_end)
              && (vpos >= cur_y) && ({1'b0, vpos} < y_end);

  logic [10:0] s1_ox;
  logic [10:0] s1_oy;
  logic        s1_inbox;
  logic        s1_de;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_btn_l;
  logic        s1_btn_r;

  // Register offsets, box hit and the first sync delay tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ox    <= 11'd0;
      s1_oy    <= 11'd0;
      s1_inbox <= 1'b0;
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_btn_l <= 1'b0;
      s1_btn_r <= 1'b0;
    end else begin
      s1_ox    <= ox;
      s1_oy    <= oy;
      s1_inbox <= inbox;
      s1_de    <= display_on;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s1_btn_l <= cur_btn_l;
      s1_btn_r <= cur_btn_r;
    end
  end

  // ---------------- Stage 2: colour selection -------------------------------
  logic on_edge;
  rgb_t pix_next;

  // Priority: blanking, background, outline, then button-dependent fill
  always_comb begin
    on_edge  = (s1_ox == 11'd0) || (s1_ox == 11'(CUR_W - 1))
            || (s1_oy == 11'd0) || (s1_oy == 11'(CUR_H - 1));
    pix_next = 12'h000;
    if (!s1_de) begin
      pix_next = 12'h000;
    end else if (!s1_inbox) begin
      pix_next = BG_RGB;
    end else if (on_edge) begin
      pix_next = BORDER_RGB;
    end else begin
      pix_next = fill_colour(s1_btn_l, s1_btn_r);
    end
  end

  // Output registers keep colour and syncs aligned at the same latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      rgb       <= pix_next;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      de_out    <= s1_de;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cursor_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_cursor_overlay
// Description : Self-checking bench for cursor_overlay with a behavioural
//               cursor/pixel model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cursor_overlay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        display_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        pkt_valid;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        btn_l;
  logic        btn_r;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic [10:0] cur_x;
  logic [10:0] cur_y;

  cursor_overlay dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pkt_valid  (pkt_valid),
    .dx         (dx),
    .dy         (dy),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .de_out     (de_out),
    .cur_x      (cur_x),
    .cur_y      (cur_y)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: pending and committed cursor position and buttons
  int px, py, cx, cy;
  bit pl, pr, cl, cr;

  typedef struct {
    int rgb;
    bit hs;
    bit vs;
    bit de;
    int cx;
    int cy;
  } exp_t;

  exp_t q[$];
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    px = 392; py = 292; cx = 392; cy = 292;
    pl = 0; pr = 0; cl = 0; cr = 0;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Colour a pixel must have given the committed cursor state
  function automatic int model_rgb(input int h, input int v, input bit de);
    bit in_box;
    if (!de) return 'h000;
    in_box = (h >= cx) && (h < cx + 16) && (v >= cy) && (v < cy + 16);
    if (!in_box) return 'h124;
    if (h == cx || h == cx + 15 || v == cy || v == cy + 15) return 'hFFF;
    if (cl && cr) return 'hFF0;
    if (cl)       return 'hF00;
    if (cr)       return 'h0F0;
    return 'h000;
  endfunction

  // One clock of stimulus; model advances as the DUT edge will
  task automatic drive(input int h, input int v, input bit de, input bit hs, input bit vs,
                       input bit pv, input int ddx, input int ddy, input bit bl, input bit br);
    exp_t e;
    @(posedge clk);
    #1;
    hpos = 11'(h); vpos = 11'(v);
    display_on = de; hsync_in = hs; vsync_in = vs;
    pkt_valid = pv; dx = 9'(ddx); dy = 9'(ddy); btn_l = bl; btn_r = br;
    e.rgb = model_rgb(h, v, de);
    e.hs = hs; e.vs = vs; e.de = de;
    if (h == 0 && v == 600) begin
      cx = px; cy = py; cl = pl; cr = pr;
    end
    if (pv) begin
      px = clampi(px + ddx, 784);
      py = clampi(py - ddy, 584);
      pl = bl; pr = br;
    end
    e.cx = cx; e.cy = cy;
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1000, 620, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic commit_frame();
    drive(0, 600, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic pkt(input int ddx, input int ddy, input bit bl, input bit br);
    drive(500, 620, 0, 0, 0, 1, ddx, ddy, bl, br);
  endtask

  task automatic pix(input string name, input int h, input int v, input logic [11:0] exp);
    drive(h, v, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    check(name, rgb, exp);
  endtask

  // Inputs held while reset releases must not disturb the model
  task automatic park_inputs();
    hpos = 11'd1000; vpos = 11'd620; display_on = 0; hsync_in = 0; vsync_in = 0;
    pkt_valid = 0; dx = '0; dy = '0; btn_l = 0; btn_r = 0;
  endtask

  // Compare every output against the model, two cycles after stimulus
  always @(negedge clk) begin
    exp_t e;
    if (chk_en && q.size() >= 3) begin
      e = q.pop_front();
      check("rgb",       rgb,       e.rgb);
      check("hsync_out", hsync_out, e.hs);
      check("vsync_out", vsync_out, e.vs);
      check("de_out",    de_out,    e.de);
      check("cur_x",     cur_x,     q[0].cx);
      check("cur_y",     cur_y,     q[0].cy);
    end
  end

  initial begin
    int h, v, ddx, ddy, r;
    rst_n = 1'b0;
    park_inputs();
    model_reset();
    #23;
    check("rst_rgb",   rgb,       12'h000);
    check("rst_hs",    hsync_out, 1'b0);
    check("rst_vs",    vsync_out, 1'b0);
    check("rst_de",    de_out,    1'b0);
    check("rst_cur_x", cur_x,     11'd392);
    check("rst_cur_y", cur_y,     11'd292);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Centred cursor drawn without any commit
    pix("corner_tl", 392, 292, 12'hFFF);
    pix("interior",  400, 300, 12'h000);
    pix("left_bg",   391, 300, 12'h124);
    pix("corner_br", 407, 307, 12'hFFF);
    pix("right_bg",  408, 300, 12'h124);
    drive(900, 300, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    check("blank_rgb", rgb, 12'h000);

    // Latency: display_on falls and hsync rises together
    drive(799, 100, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(800, 100, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    check("lat_de_a",  de_out,    1'b1);
    check("lat_hs_a",  hsync_out, 1'b0);
    check("lat_rgb_a", rgb,       12'h124);
    idle();
    check("lat_de_b",  de_out,    1'b0);
    check("lat_hs_b",  hsync_out, 1'b1);
    check("lat_rgb_b", rgb,       12'h000);

    // Movement waits for the commit point
    drive(100, 100, 1, 0, 0, 1, 10, 5, 0, 0);
    idle();
    check("hold_x", cur_x, 11'd392);
    check("hold_y", cur_y, 11'd292);
    commit_frame();
    check("move_x", cur_x, 11'd402);
    check("move_y", cur_y, 11'd287);

    // Clamp at the right and top edges, then at the left edge
    pkt(255, 255, 0, 0); pkt(255, 255, 0, 0);
    pkt(255, 0, 0, 0);   pkt(255, 0, 0, 0);
    commit_frame();
    check("clamp_xmax", cur_x, 11'd784);
    check("clamp_y0",   cur_y, 11'd0);
    for (int i = 0; i < 4; i++) pkt(-256, 0, 0, 0);
    commit_frame();
    check("clamp_x0", cur_x, 11'd0);
    pkt(-256, 0, 0, 0);
    commit_frame();
    check("clamp_x0_stay", cur_x, 11'd0);

    // Buttons select the fill colour
    pkt(100, -100, 1, 1);
    commit_frame();
    pix("fill_both", 108, 108, 12'hFF0);
    pix("edge_both", 100, 100, 12'hFFF);
    pix("edge_r",    115, 110, 12'hFFF);
    pkt(0, 0, 0, 1);
    commit_frame();
    pix("fill_right", 108, 108, 12'h0F0);

    // Packet on the commit cycle is deferred one frame
    drive(0, 600, 0, 0, 0, 1, 1, 0, 0, 1);
    idle();
    check("coinc_x_old", cur_x, 11'd100);
    commit_frame();
    check("coinc_x_new", cur_x, 11'd101);

    // Random traffic around and away from the cursor
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        h = 0; v = 600;
      end else if (r < 60) begin
        h = clampi(cx + int'($urandom_range(0, 23)) - 4, 1055);
        v = clampi(cy + int'($urandom_range(0, 23)) - 4, 627);
      end else begin
        h = int'($urandom_range(0, 1055));
        v = int'($urandom_range(0, 627));
      end
      if ($urandom_range(0, 1) == 1) begin
        ddx = int'($urandom_range(0, 40)) - 20;
        ddy = int'($urandom_range(0, 40)) - 20;
      end else begin
        ddx = int'($urandom_range(0, 511)) - 256;
        ddy = int'($urandom_range(0, 511)) - 256;
      end
      drive(h, v, (h < 800) && (v < 600), (h >= 840) && (h < 968), (v >= 601) && (v < 605),
            $urandom_range(0, 3) == 0, ddx, ddy,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a line
    drive(395, 295, 1, 0, 0, 1, 7, 7, 1, 1);
    #3;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    q.delete();
    #1;
    check("mid_rst_rgb", rgb,       12'h000);
    check("mid_rst_hs",  hsync_out, 1'b0);
    check("mid_rst_de",  de_out,    1'b0);
    check("mid_rst_x",   cur_x,     11'd392);
    check("mid_rst_y",   cur_y,     11'd292);
    model_reset();
    park_inputs();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    pix("post_rst_corner", 392, 292, 12'hFFF);
    pix("post_rst_fill",   400, 300, 12'h000);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Pixel-generation stage directly downstream of the 800x600 sync/position generator.
- Consumes hpos/vpos/display_on/hsync/vsync and decoded PS/2 mouse movement packets.
- Keeps a clamped cursor position and draws a 16x16 box cursor over a flat background.
- Emits 12-bit RGB plus sync signals, all delayed to the same latency.

Parameters:
- H_DISPLAY, 800, visible width in pixels
- V_DISPLAY, 600, visible height in lines
- CUR_W, 16, cursor width in pixels
- CUR_H, 16, cursor height in lines
- BG_RGB, 12'h124, background colour (4:4:4)
- BORDER_RGB, 12'hFFF, cursor outline colour

Ports:
- clk  in  1  pixel clock, shared with the sync generator
- rst_n  in  1  asynchronous active-low reset
- hpos  in  11  current horizontal pixel position
- vpos  in  11  current line position
- display_on  in  1  visible-area flag
- hsync_in  in  1  horizontal sync from the generator
- vsync_in  in  1  vertical sync from the generator
- pkt_valid  in  1  one-cycle strobe; a mouse packet is present
- dx  in  9  signed two's-complement X movement; positive = right
- dy  in  9  signed two's-complement Y movement; positive = up (PS/2 convention)
- btn_l  in  1  left button state, sampled with pkt_valid
- btn_r  in  1  right button state, sampled with pkt_valid
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- de_out  out  1  display_on delayed 2 cycles
- cur_x  out  11  committed cursor X, for debug/LEDs
- cur_y  out  11  committed cursor Y, for debug/LEDs

Behaviour:
- Reset is asynchronous, active-low, on clk domain. Reset values:
  - Pending and committed position x = (H_DISPLAY-CUR_W)/2 = 392, y = (V_DISPLAY-CUR_H)/2 = 292.
  - Buttons 0.
  - rgb=0, hsync_out=0, vsync_out=0, de_out=0.
  - All pipeline registers 0.
- Pending position update, on pkt_valid:
  - nx = px + sext(dx); ny = py - sext(dy).
  - Computed in 13-bit signed arithmetic.
  - Each coordinate clamped to [0, H_DISPLAY-CUR_W] and [0, V_DISPLAY-CUR_H] (0..784, 0..584).
  - btn_l/btn_r latched into pending button state in the same cycle.
  - Back-to-back pkt_valid cycles accumulate every packet; none are dropped.
- Commit (anti-tearing):
  - On the cycle where hpos==0 and vpos==V_DISPLAY, the pending position and buttons are copied into the committed registers (cur_x/cur_y).
  - Committed values are stable for the entire visible frame.
  - If pkt_valid coincides with the commit cycle, the commit takes the pre-update pending value; the new packet appears the following frame.
- Pixel pipeline, 2 cycles:
  - S1 registers: ox = hpos-cur_x, oy = vpos-cur_y (11-bit unsigned wrap); inbox = display_on && hpos>=cur_x && hpos<cur_x+CUR_W && vpos>=cur_y && vpos<cur_y+CUR_H; edge = ox==0 || ox==CUR_W-1 || oy==0 || oy==CUR_H-1; delayed display_on/hsync/vsync.
  - S2 rgb selection:
    - !de gives 0.
    - !inbox gives BG_RGB.
    - edge gives BORDER_RGB.
    - Otherwise fill colour: none 12'h000, left 12'hF00, right 12'h0F0, both 12'hFF0.
- Latency: rgb, hsync_out, vsync_out and de_out all lag the inputs by exactly 2 clk; the relative timing of sync and data is preserved.
- Reset mid-frame: outputs go to 0 immediately; the pipeline refills within 2 cycles after release. The cursor reappears centred from the first commit after reset; the committed value is already centred, so it is drawn at once.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header holds:
  - Timing constants H_DISPLAY, V_DISPLAY, H_MAX, V_MAX, common with the sync generator.
  - Colour constants.
  - A 12-bit RGB typedef.
- One natural sub-module, cursor_pos_accum: clamped accumulator plus frame-commit registers. cursor_overlay instantiates it and contains the 2-stage draw pipeline.

Test Plan:
- Reset, then one full frame with no packets -> cursor box spans x 392..407, y 292..307. Pixel (392,292) is 12'hFFF, (400,300) is 12'h000, (391,300) is 12'h124. Blanking gives 0.
- pkt dx=+10, dy=+5 mid-frame -> cur_x/cur_y unchanged until hpos==0 && vpos==600, then 402/287.
- Clamp: from x=392, send dx=+255 four times -> cur_x=784. From y=292, dy=+255 twice -> cur_y=0. Also check dx=-256 at x=0 stays 0.
- Buttons: pkt with btn_l=1, btn_r=1 -> interior pixels 12'hFF0 next frame. btn_r only -> 12'h0F0.
- Latency: drive a hsync_in/display_on edge -> hsync_out/de_out toggle exactly 2 clk later, aligned with the rgb transition to/from 0.
- pkt_valid on the commit cycle (dx=+1) -> that frame still uses the old x; the next frame x advances by 1. Then assert rst_n low mid-line -> all outputs 0 asynchronously, and position returns to 392/292.
